// File: rtl/re_demapper.sv
// re_demapper: pulls DMRS comb and data REs of one allocation out of the resource grid,
// symbol by symbol, presenting them with a fixed two-cycle read latency.
module re_demapper #(
  parameter int FFT_Len  = 18,
  parameter int Total_Sc = 1200
) (
  input  logic                      CLK_RE,
  input  logic                      RST_RE,
  input  logic                      Start,
  input  logic [10:0]               N_sc,
  input  logic [6:0]                N_rb,
  input  logic [3:0]                Sym_Start,
  input  logic [3:0]                Sym_End,
  input  logic                      Grid_Ready,
  output logic                      Rd_en,
  output logic [10:0]               Rd_addr,
  output logic [3:0]                Rd_sym,
  input  logic signed [FFT_Len-1:0] Rd_I,
  input  logic signed [FFT_Len-1:0] Rd_Q,
  output logic signed [FFT_Len-1:0] DMRS_I,
  output logic signed [FFT_Len-1:0] DMRS_Q,
  output logic                      DMRS_Valid,
  output logic [9:0]                DMRS_Idx,
  output logic signed [FFT_Len-1:0] Data_I,
  output logic signed [FFT_Len-1:0] Data_Q,
  output logic                      Data_Valid,
  output logic [10:0]               Data_Idx,
  output logic [3:0]                Data_Sym,
  output logic                      Busy,
  output logic                      Sym_Done,
  output logic                      Demap_Done,
  output logic                      Cfg_Err
);
  typedef enum logic [1:0] {IDLE, WAIT_SYM, READ, DRAIN} state_t;
  state_t r_state, w_next;
  logic [10:0] r_nsc;
  logic [11:0] r_last;
  logic [3:0]  r_sym_start, r_sym_end;
  logic        r_drain;
  logic        r_rd_en;
  logic [10:0] r_rd_addr;
  logic [3:0]  r_rd_sym;
  logic        r_busy, r_cfg_err;
  logic        r_p_vld, r_p_dmrs, r_p_last, r_p_fin;
  logic [10:0] r_p_idx;
  logic [3:0]  r_p_sym;
  logic signed [FFT_Len-1:0] r_dmrs_i, r_dmrs_q, r_data_i, r_data_q;
  logic        r_dmrs_vld, r_data_vld, r_sym_done, r_demap_done;
  logic [9:0]  r_dmrs_idx;
  logic [10:0] r_data_idx;
  logic [3:0]  r_data_sym;
  logic [11:0] w_last_in, w_last_addr;
  logic        w_cfg_bad, w_accept, w_dmrs, w_last_rd, w_final, w_p_dmrs, w_p_data;
  assign w_last_in   = {1'b0, N_sc} + 12'(N_rb) * 12'd12;
  assign w_cfg_bad   = (N_rb == 7'd0) || (w_last_in > 12'(Total_Sc)) || (Sym_End <= Sym_Start);
  assign w_accept    = Start && (r_state == IDLE) && !w_cfg_bad;
  assign w_dmrs      = r_rd_sym == r_sym_start;
  assign w_last_addr = r_last - (w_dmrs ? 12'd2 : 12'd1);
  assign w_last_rd   = r_rd_en && ({1'b0, r_rd_addr} == w_last_addr);
  assign w_final     = r_rd_sym == r_sym_end;
  assign w_p_dmrs    = r_p_vld && r_p_dmrs;
  assign w_p_data    = r_p_vld && !r_p_dmrs;
  always_ff @(posedge CLK_RE)
    if (RST_RE) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_accept ? WAIT_SYM : IDLE;
      WAIT_SYM: w_next = Grid_Ready ? READ : WAIT_SYM;
      READ:     w_next = w_last_rd ? DRAIN : READ;
      DRAIN:    w_next = r_drain ? (w_final ? IDLE : WAIT_SYM) : DRAIN;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK_RE) begin
    if (RST_RE) begin
      r_nsc <= '0; r_last <= '0; r_sym_start <= '0; r_sym_end <= '0; r_drain <= 1'b0;
      r_rd_en <= 1'b0; r_rd_addr <= '0; r_rd_sym <= '0; r_busy <= 1'b0; r_cfg_err <= 1'b0;
      r_p_vld <= 1'b0; r_p_dmrs <= 1'b0; r_p_last <= 1'b0; r_p_fin <= 1'b0; r_p_idx <= '0; r_p_sym <= '0;
      r_dmrs_i <= '0; r_dmrs_q <= '0; r_data_i <= '0; r_data_q <= '0;
      r_dmrs_vld <= 1'b0; r_data_vld <= 1'b0; r_sym_done <= 1'b0; r_demap_done <= 1'b0;
      r_dmrs_idx <= '0; r_data_idx <= '0; r_data_sym <= '0;
    end else begin
      r_cfg_err <= Start && (r_state == IDLE) && w_cfg_bad;
      if (w_accept) begin
        r_nsc       <= N_sc;
        r_last      <= w_last_in;
        r_sym_start <= Sym_Start;
        r_sym_end   <= Sym_End;
        r_rd_sym    <= Sym_Start;
      end else if (r_state == DRAIN && r_drain && !w_final) r_rd_sym <= r_rd_sym + 4'd1;
      r_drain <= (r_state == DRAIN) && !r_drain;
      r_busy  <= w_next != IDLE;
      r_rd_en <= w_next == READ;
      if (r_state == WAIT_SYM && Grid_Ready) r_rd_addr <= r_nsc;
      else if (r_rd_en && !w_last_rd)        r_rd_addr <= r_rd_addr + (w_dmrs ? 11'd2 : 11'd1);
      // stage 1 tracks the read issued this cycle; its sample arrives next cycle
      r_p_vld  <= r_rd_en;
      r_p_dmrs <= w_dmrs;
      r_p_idx  <= r_rd_addr - r_nsc;
      r_p_sym  <= r_rd_sym;
      r_p_last <= w_last_rd;
      r_p_fin  <= w_last_rd && w_final;
      r_dmrs_vld   <= w_p_dmrs;
      r_data_vld   <= w_p_data;
      r_dmrs_i     <= w_p_dmrs ? Rd_I : '0;
      r_dmrs_q     <= w_p_dmrs ? Rd_Q : '0;
      r_data_i     <= w_p_data ? Rd_I : '0;
      r_data_q     <= w_p_data ? Rd_Q : '0;
      r_dmrs_idx   <= w_p_dmrs ? r_p_idx[10:1] : '0;
      r_data_idx   <= w_p_data ? r_p_idx : '0;
      r_data_sym   <= r_p_sym;
      r_sym_done   <= r_p_last;
      r_demap_done <= r_p_fin;
    end
  end
  assign Rd_en      = r_rd_en;
  assign Rd_addr    = r_rd_addr;
  assign Rd_sym     = r_rd_sym;
  assign DMRS_I     = r_dmrs_i;
  assign DMRS_Q     = r_dmrs_q;
  assign DMRS_Valid = r_dmrs_vld;
  assign DMRS_Idx   = r_dmrs_idx;
  assign Data_I     = r_data_i;
  assign Data_Q     = r_data_q;
  assign Data_Valid = r_data_vld;
  assign Data_Idx   = r_data_idx;
  assign Data_Sym   = r_data_sym;
  assign Busy       = r_busy;
  assign Sym_Done   = r_sym_done;
  assign Demap_Done = r_demap_done;
  assign Cfg_Err    = r_cfg_err;
endmodule
